// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the 800x600 @ 60 Hz, 40 MHz display path.
//   HOR_PIXELS / VER_PIXELS : visible area of the screen
//   hdir_t                  : horizontal motion direction of an animated object
//   vdir_t                  : vertical motion direction of an animated object
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

    typedef enum logic {
        RIGHT = 1'b0,
        LEFT  = 1'b1
    } hdir_t;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } vdir_t;

endpackage

// File: rtl/rect_pos_ctl.sv
// ----------------------------------------------------------------------------
// rect_pos_ctl
// Keeps the top-left corner of the bouncing rectangle. Once per frame, on the
// rising edge of vertical blank, each axis moves by STEP and reverses at the
// screen edges.
// Ports:
//   clk      in   pixel clock
//   rst      in   synchronous reset, active-high
//   en       in   motion enable, only looked at on the frame strobe
//   vblnk_in in   vertical blank from the timing stage
//   x, y     out  rectangle top-left corner (11 bit)
// ----------------------------------------------------------------------------
import vga_pkg::*;

module rect_pos_ctl #(
    parameter int RECT_W = 64,
    parameter int RECT_H = 48,
    parameter int STEP   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        vblnk_in,
    output logic [10:0] x,
    output logic [10:0] y
);

    localparam logic [10:0] X_MAX = 11'(HOR_PIXELS - RECT_W);
    localparam logic [10:0] Y_MAX = 11'(VER_PIXELS - RECT_H);

    logic [10:0] r_x;
    logic [10:0] r_y;
    hdir_t       r_hdir;
    vdir_t       r_vdir;
    logic        r_prevVblnk;
    logic        r_justReset;
    logic        r_vblnkAtReset;

    logic        w_prevVblnkEff;
    logic        w_strobe;
    logic [11:0] w_xFarEdge;
    logic [11:0] w_yFarEdge;
    logic        w_xHitRight;
    logic        w_yHitBottom;
    logic        w_xHitLeft;
    logic        w_yHitTop;

    // Edge detect for the frame strobe. On the first cycle after reset the
    // level seen while reset was held stands in for the previous sample, so a
    // vblnk that is already high when reset releases is not taken as a rise.
    always_comb begin
        w_prevVblnkEff = r_justReset ? r_vblnkAtReset : r_prevVblnk;
        w_strobe       = vblnk_in & ~w_prevVblnkEff;
    end

    // Edge tests are done in 12 bits so adding STEP and the rectangle size can
    // never wrap. The direction turns on the frame the rectangle arrives at an
    // edge, so it does not sit still at the edge for an extra frame.
    always_comb begin
        w_xFarEdge   = {1'b0, r_x} + 12'(STEP) + 12'(RECT_W);
        w_yFarEdge   = {1'b0, r_y} + 12'(STEP) + 12'(RECT_H);
        w_xHitRight  = (w_xFarEdge >= 12'(HOR_PIXELS));
        w_yHitBottom = (w_yFarEdge >= 12'(VER_PIXELS));
        w_xHitLeft   = ({1'b0, r_x} <= 12'(STEP));
        w_yHitTop    = ({1'b0, r_y} <= 12'(STEP));
    end

    // Position and direction state machines for both axes. The axes are
    // independent; both only move on the frame strobe while en is high, and
    // reset wins over a strobe in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x            <= '0;
            r_y            <= '0;
            r_hdir         <= RIGHT;
            r_vdir         <= DOWN;
            r_prevVblnk    <= 1'b0;
            r_justReset    <= 1'b1;
            r_vblnkAtReset <= vblnk_in;
        end else begin
            r_prevVblnk <= vblnk_in;
            r_justReset <= 1'b0;
            if (w_strobe && en) begin
                case (r_hdir)
                    RIGHT: begin
                        if (w_xHitRight) begin
                            r_x    <= X_MAX;
                            r_hdir <= LEFT;
                        end else begin
                            r_x <= r_x + 11'(STEP);
                        end
                    end
                    LEFT: begin
                        if (w_xHitLeft) begin
                            r_x    <= '0;
                            r_hdir <= RIGHT;
                        end else begin
                            r_x <= r_x - 11'(STEP);
                        end
                    end
                    default: r_hdir <= RIGHT;
                endcase
                case (r_vdir)
                    DOWN: begin
                        if (w_yHitBottom) begin
                            r_y    <= Y_MAX;
                            r_vdir <= UP;
                        end else begin
                            r_y <= r_y + 11'(STEP);
                        end
                    end
                    UP: begin
                        if (w_yHitTop) begin
                            r_y    <= '0;
                            r_vdir <= DOWN;
                        end else begin
                            r_y <= r_y - 11'(STEP);
                        end
                    end
                    default: r_vdir <= DOWN;
                endcase
            end
        end
    end

    assign x = r_x;
    assign y = r_y;

endmodule

// File: rtl/draw_rect_anim.sv
// ----------------------------------------------------------------------------
// draw_rect_anim
// Draw stage that overlays a solid, bouncing rectangle on the incoming
// background and forwards the timing bus with one cycle of delay.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   en                           motion enable
//   hcount_in, vcount_in         pixel position (11 bit)
//   hsync_in, vsync_in           sync from the timing stage
//   hblnk_in, vblnk_in           blanking from the timing stage
//   rgb_in                       background colour, RGB 4:4:4
//   hcount_out ... vblnk_out     registered copies of the bus
//   rgb_out                      composed colour
// ----------------------------------------------------------------------------
import vga_pkg::*;

module draw_rect_anim #(
    parameter int          RECT_W     = 64,
    parameter int          RECT_H     = 48,
    parameter logic [11:0] RECT_COLOR = 12'hF_0_0,
    parameter int          STEP       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    logic [10:0] w_x;
    logic [10:0] w_y;
    logic        w_inside;
    logic [11:0] w_rgbNext;

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_hblnk;
    logic        r_vblnk;
    logic [11:0] r_rgb;

    rect_pos_ctl #(
        .RECT_W (RECT_W),
        .RECT_H (RECT_H),
        .STEP   (STEP)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .vblnk_in (vblnk_in),
        .x        (w_x),
        .y        (w_y)
    );

    // Inclusive bounds test on the current pixel, widened to 12 bits so the
    // far edge of the rectangle cannot wrap. Blanking always forces black.
    always_comb begin
        w_inside = ({1'b0, hcount_in} >= {1'b0, w_x}) &&
                   ({1'b0, hcount_in} <= ({1'b0, w_x} + 12'(RECT_W - 1))) &&
                   ({1'b0, vcount_in} >= {1'b0, w_y}) &&
                   ({1'b0, vcount_in} <= ({1'b0, w_y} + 12'(RECT_H - 1)));
        if (hblnk_in || vblnk_in) begin
            w_rgbNext = 12'h0_0_0;
        end else if (w_inside) begin
            w_rgbNext = RECT_COLOR;
        end else begin
            w_rgbNext = rgb_in;
        end
    end

    // One-cycle delay of the whole bus together with the composed colour, so
    // everything downstream stays aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
            r_hblnk  <= 1'b0;
            r_vblnk  <= 1'b0;
            r_rgb    <= '0;
        end else begin
            r_hcount <= hcount_in;
            r_vcount <= vcount_in;
            r_hsync  <= hsync_in;
            r_vsync  <= vsync_in;
            r_hblnk  <= hblnk_in;
            r_vblnk  <= vblnk_in;
            r_rgb    <= w_rgbNext;
        end
    end

    assign hcount_out = r_hcount;
    assign vcount_out = r_vcount;
    assign hsync_out  = r_hsync;
    assign vsync_out  = r_vsync;
    assign hblnk_out  = r_hblnk;
    assign vblnk_out  = r_vblnk;
    assign rgb_out    = r_rgb;

endmodule
